// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage
//   Elastic pipeline register: DEPTH slices of WIDTH bits joined by a
//   valid/ready handshake. Bubbles collapse under back-pressure, a
//   synchronous flush drops every in-flight word, and the number of valid
//   slices is reported on occupancy.
//   in_ready is a combinational function of out_ready and the slice valids.
//   Downstream logic must not make out_ready depend on in_valid.
module pipe_reg_stage #(
   parameter  int                 WIDTH     = 28,
   parameter  int                 DEPTH     = 2,
   parameter  logic [WIDTH-1:0]   RESET_VAL = '0,
   localparam int                 CW        = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [CW-1:0]     occupancy
);

   // Slice state: valid bit and data word for each slice.
   // Slice DEPTH-1 is the output slice.
   logic [DEPTH-1:0]  r_v;
   logic [WIDTH-1:0]  r_d [DEPTH];

   // Combinational helpers
   logic [DEPTH-1:0]  w_rdy;          // slice k may load this edge
   logic [DEPTH-1:0]  w_up_v;         // valid presented to slice k
   logic [WIDTH-1:0]  w_up_d [DEPTH]; // data presented to slice k

   // Slice k can load when the slice itself or any slice downstream of it
   // has a hole, or when the output is being drained. This is the unrolled
   // form of r[k] = !v[k] | r[k+1], computed directly from the registered
   // valids so no signal depends on itself.
   function automatic logic slice_ready(input logic [DEPTH-1:0] v,
                                        input logic             o_rdy,
                                        input int               k);
      logic rdy;
      rdy = o_rdy;
      for (int j = 0; j < DEPTH; j++) begin
         if ((j >= k) && !v[j]) begin
            rdy = 1'b1;
         end else begin
            rdy = rdy;
         end
      end
      return rdy;
   endfunction

   // Number of set valid bits.
   function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int j = 0; j < DEPTH; j++) begin
         cnt = cnt + CW'(v[j]);
      end
      return cnt;
   endfunction

   // Ready chain derived from the slice valids and the downstream ready.
   always_comb begin
      w_rdy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_rdy[k] = slice_ready(r_v, out_ready, k);
      end
   end

   // Upstream source of every slice.
   // Slice 0 sees the input port, and each later slice sees its predecessor.
   always_comb begin
      w_up_v    = '0;
      w_up_d[0] = in_data;
      w_up_v[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         w_up_v[k] = r_v[k-1];
         w_up_d[k] = r_d[k-1];
      end
   end

   // Slice valid bits.
   // Flush clears all valids and overrides any load in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_v <= '0;
      end else if (flush) begin
         r_v <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_rdy[k]) begin
               r_v[k] <= w_up_v[k];
            end
         end
      end
   end

   // Slice data words.
   // A slice captures new data only when a valid word moves into it; otherwise
   // it keeps its last word, so out_data holds its value while the stage is empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_d[k] <= RESET_VAL;
         end
      end else if (!flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_rdy[k] && w_up_v[k]) begin
               r_d[k] <= w_up_d[k];
            end
         end
      end
   end

   // Port outputs: the output slice and the input-side ready.
   // Occupancy is decoded from the registered valids, so it is stable for the whole cycle.
   always_comb begin
      in_ready  = w_rdy[0] & ~flush;
      out_valid = r_v[DEPTH-1];
      out_data  = r_d[DEPTH-1];
      occupancy = popcount(r_v);
   end

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Testbench for pipe_reg_stage: directed vectors plus a random phase.
// It uses two instances:
//   dut_a: WIDTH=28, DEPTH=3
//   dut_b: WIDTH=56, DEPTH=1, RESET_VAL=56'hF
// Each instance has a scoreboard queue. A word is pushed when the DUT accepts it
// and popped when the DUT delivers a word. A flush or a reset empties the queue.
module tb_pipe_reg_stage;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // DUT A signals
   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [27:0] a_in_data, a_out_data;
   logic [1:0]  a_occ;
   // DUT B signals
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [55:0] b_in_data, b_out_data;
   logic [0:0]  b_occ;

   int n_chk  = 0;
   int n_fail = 0;

   logic [27:0] qa[$];
   logic [55:0] qb[$];

   pipe_reg_stage #(.WIDTH(28), .DEPTH(3), .RESET_VAL(28'h0)) dut_a (
      .clk(clk), .rstn(rstn), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occ));

   pipe_reg_stage #(.WIDTH(56), .DEPTH(1), .RESET_VAL(56'hF)) dut_b (
      .clk(clk), .rstn(rstn), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occ));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard for DUT A, sampled on the falling edge.
   // Within a cycle it handles, in order: the output transfer, then flush, then the input transfer.
   always @(negedge clk) begin
      if (rstn) begin
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_out", {36'h0, a_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("a_out_data", {36'h0, a_out_data}, {36'h0, qa.pop_front()});
            end
         end
         if (a_flush) begin
            qa.delete();
         end else if (a_in_valid && a_in_ready) begin
            qa.push_back(a_in_data);
         end
      end
   end

   // Scoreboard for DUT B.
   always @(negedge clk) begin
      if (rstn) begin
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_out", {8'h0, b_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("b_out_data", {8'h0, b_out_data}, {8'h0, qb.pop_front()});
            end
         end
         if (b_flush) begin
            qb.delete();
         end else if (b_in_valid && b_in_ready) begin
            qb.push_back(b_in_data);
         end
      end
   end

   // A reset discards every word in flight.
   always @(negedge rstn) begin
      qa.delete();
      qb.delete();
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drain DUT A with a cycle budget, then require that it is empty.
   task automatic drain_a();
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
      end
      @(negedge clk);
      chk("a_drain_occ", 64'(a_occ), 64'd0);
      next_cycle();
   endtask

   initial begin
      rstn = 1'b0;
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 28'h0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 56'h0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Reset state of both instances
      @(negedge clk);
      chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
      chk("a_rst_occ",       64'(a_occ),       64'd0);
      chk("a_rst_out_data",  64'(a_out_data),  64'd0);
      chk("a_rst_in_ready",  64'(a_in_ready),  64'd1);
      chk("b_rst_out_data",  64'(b_out_data),  64'hF);
      chk("b_rst_in_ready",  64'(b_in_ready),  64'd1);
      next_cycle();

      // Streaming: words 1..20 are offered on cycles 0..19.
      // Word 1 is expected at cycle 3, and the rest follow with no gaps.
      a_out_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
         a_in_valid = (c < 20);
         a_in_data  = 28'(c + 1);
         @(negedge clk);
         chk("a_stream_valid", 64'(a_out_valid), 64'((c >= 3) && (c <= 22)));
         if ((c >= 3) && (c <= 22)) begin
            chk("a_stream_data", 64'(a_out_data), 64'(c - 2));
         end
         next_cycle();
      end
      a_in_valid = 1'b0;

      // Back-pressure: load A, B and C while the output is stalled.
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 28'(28'hA0 + i);
         next_cycle();
      end
      a_in_data = 28'hD0;
      @(negedge clk);
      chk("a_full_occ",      64'(a_occ),       64'd3);
      chk("a_full_in_ready", 64'(a_in_ready),  64'd0);
      chk("a_full_out_data", 64'(a_out_data),  64'hA0);
      next_cycle();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("a_full_pass_in_ready", 64'(a_in_ready), 64'd1);
      next_cycle();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b0;
      @(negedge clk);
      chk("a_full_pass_occ",  64'(a_occ),      64'd3);
      chk("a_full_pass_data", 64'(a_out_data), 64'hA1);
      next_cycle();
      drain_a();

      // Bubble collapse: send A, stay idle for 2 cycles, then send B while stalled.
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 28'h0B1; next_cycle();
      a_in_valid = 1'b0; next_cycle(); next_cycle();
      a_in_valid = 1'b1; a_in_data = 28'h0B2; next_cycle();
      a_in_valid = 1'b0; next_cycle();
      @(negedge clk);
      chk("a_bubble_occ",  64'(a_occ),      64'd2);
      chk("a_bubble_data", 64'(a_out_data), 64'h0B1);
      next_cycle();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("a_bubble_rel0_v", 64'(a_out_valid), 64'd1);
      chk("a_bubble_rel0_d", 64'(a_out_data),  64'h0B1);
      next_cycle();
      @(negedge clk);
      chk("a_bubble_rel1_v", 64'(a_out_valid), 64'd1);
      chk("a_bubble_rel1_d", 64'(a_out_data),  64'h0B2);
      next_cycle();
      @(negedge clk);
      chk("a_bubble_rel2_v", 64'(a_out_valid), 64'd0);
      next_cycle();

      // Flush: fill the stage, then raise flush while 0xABCDEF is offered on the input.
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 28'(28'h111 * (i + 1));
         next_cycle();
      end
      a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 28'hABCDEF;
      @(negedge clk);
      chk("a_flush_in_ready", 64'(a_in_ready), 64'd0);
      next_cycle();
      a_flush = 1'b0; a_in_valid = 1'b0;
      @(negedge clk);
      chk("a_flush_occ",       64'(a_occ),       64'd0);
      chk("a_flush_out_valid", 64'(a_out_valid), 64'd0);
      chk("a_flush_data_hold", 64'(a_out_data),  64'h111);
      next_cycle();
      a_in_valid = 1'b1; a_in_data = 28'h55; next_cycle();
      drain_a();

      // Reset in the middle of a transfer, with occupancy = 2
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 28'h71; next_cycle();
      a_in_data = 28'h72; next_cycle();
      a_in_valid = 1'b0; next_cycle();
      @(negedge clk);
      chk("a_pre_rst_occ", 64'(a_occ), 64'd2);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("a_midrst_out_valid", 64'(a_out_valid), 64'd0);
      chk("a_midrst_occ",       64'(a_occ),       64'd0);
      chk("a_midrst_out_data",  64'(a_out_data),  64'd0);
      next_cycle();
      rstn = 1'b1;
      @(negedge clk);
      chk("a_post_rst_in_ready", 64'(a_in_ready), 64'd1);
      chk("b_post_rst_out_data", 64'(b_out_data), 64'hF);
      next_cycle();

      // DUT B: latency of 1 cycle and full-rate pass-through
      b_out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         b_in_valid = (c < 6);
         b_in_data  = 56'h12_3400_0000_0000 + 56'(c);
         @(negedge clk);
         chk("b_pass_valid", 64'(b_out_valid), 64'((c >= 1) && (c <= 6)));
         if ((c >= 1) && (c <= 6)) begin
            chk("b_pass_data", 64'(b_out_data), 64'(56'h12_3400_0000_0000 + 56'(c - 1)));
         end
         next_cycle();
      end

      // Random valid/ready on both DUTs. DUT A also gets an occasional flush.
      for (int c = 0; c < 10000; c++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_out_ready = 1'($urandom_range(0, 1));
         a_in_data   = 28'($urandom);
         a_flush     = ($urandom_range(0, 31) == 0);
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_data   = {24'($urandom), 32'($urandom)};
         next_cycle();
      end
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      repeat (6) next_cycle();
      @(negedge clk);
      chk("a_rand_sb_empty", 64'(qa.size()), 64'd0);
      chk("a_rand_occ",      64'(a_occ),     64'd0);
      chk("b_rand_sb_empty", 64'(qb.size()), 64'd0);
      chk("b_rand_occ",      64'(b_occ),     64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
